// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding, default sizes and width helper for the BIST scheduler
package bist_pkg;
  typedef enum logic [3:0] {
    S_ARM, S_WAIT, S_SELECT, S_INIT, S_SHIFT, S_CAPT, S_COMPARE, S_DONE, S_END
  } state_t;
  localparam int NUM_CUT_D = 4;
  localparam int N_SHIFT_D = 3;
  localparam int M_PAT_D = 330;
  localparam int SIG_W_D = 16;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bist_if.sv
// bist_if: test-access and TPG/MISR/CUT-mux signals of the BIST scheduler
interface bist_if import bist_pkg::*; #(
  parameter int NUM_CUT = NUM_CUT_D,
  parameter int SIG_W = SIG_W_D
);
  logic START;
  logic [NUM_CUT-1:0] CUT_EN;
  logic [SIG_W-1:0] MISR_SIG;
  logic [NUM_CUT*SIG_W-1:0] GOLDEN_SIG;
  logic [cw(NUM_CUT)-1:0] CUT_SEL;
  logic INIT;
  logic SCAN_EN;
  logic CAPTURE;
  logic BUSY;
  logic BIST_END;
  logic [NUM_CUT-1:0] PASS_VEC;
  logic GO;
  modport master (
    output START, CUT_EN, MISR_SIG, GOLDEN_SIG,
    input CUT_SEL, INIT, SCAN_EN, CAPTURE, BUSY, BIST_END, PASS_VEC, GO
  );
  modport slave (
    input START, CUT_EN, MISR_SIG, GOLDEN_SIG,
    output CUT_SEL, INIT, SCAN_EN, CAPTURE, BUSY, BIST_END, PASS_VEC, GO
  );
endinterface

// File: rtl/bist_session_scheduler_counter.sv
// bist_pattern_counter: shift-cycle and pattern counters pacing each CUT's scan run
module bist_pattern_counter import bist_pkg::*; #(
  parameter int N_SHIFT = N_SHIFT_D,
  parameter int M_PAT = M_PAT_D
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic shift_inc,
  input  logic cap_inc,
  output logic shift_done,
  output logic pat_done
);
  localparam int SHW = cw(N_SHIFT + 1);
  localparam int PW = cw(M_PAT + 1);
  logic [SHW-1:0] shift_cnt;
  logic [PW-1:0] pat_cnt;
  assign shift_done = shift_inc && (shift_cnt == SHW'(N_SHIFT - 1));
  assign pat_done = cap_inc && (pat_cnt == PW'(M_PAT - 1));
  // shift count restarts on leaving SHIFT; pattern count restarts on INIT and saturates at M_PAT
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shift_cnt <= '0;
      pat_cnt <= '0;
    end else begin
      shift_cnt <= (clr || shift_done) ? '0 : shift_cnt + SHW'(shift_inc);
      pat_cnt <= clr ? '0 : pat_cnt + PW'(cap_inc);
    end
  end
endmodule

// File: rtl/bist_session_scheduler.sv
// bist_session_scheduler: walks enabled CUTs through init/scan/compare on a shared TPG/MISR
module bist_session_scheduler import bist_pkg::*; #(
  parameter int NUM_CUT = NUM_CUT_D,
  parameter int N_SHIFT = N_SHIFT_D,
  parameter int M_PAT = M_PAT_D,
  parameter int SIG_W = SIG_W_D
) (
  input logic CLK,
  input logic RESET,
  bist_if.slave bus
);
  localparam int SW = cw(NUM_CUT);
  state_t st, nxt;
  logic [NUM_CUT-1:0] en_q, tested, rem;
  logic [SW-1:0] pick;
  logic any_left, shift_done, pat_done;
  if (N_SHIFT < 1 || M_PAT < 1 || NUM_CUT < 1) begin : g_bad_param
    $error("bist_session_scheduler: N_SHIFT, M_PAT and NUM_CUT must all be >= 1");
  end
  assign rem = en_q & ~tested;
  assign any_left = |rem;
  // lowest-index enabled CUT that has not been tested yet
  always_comb begin
    pick = '0;
    for (int i = NUM_CUT - 1; i >= 0; i--) if (rem[i]) pick = SW'(i);
  end
  bist_pattern_counter #(.N_SHIFT(N_SHIFT), .M_PAT(M_PAT)) u_cnt (
    .CLK(CLK),
    .RESET(RESET),
    .clr(st == S_INIT),
    .shift_inc(st == S_SHIFT),
    .cap_inc(st == S_CAPT),
    .shift_done(shift_done),
    .pat_done(pat_done)
  );
  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) st <= S_ARM;
    else st <= nxt;
  end
  // next-state: a session needs START seen low then high, and ignores START while busy
  always_comb begin
    nxt = st;
    case (st)
      S_ARM:     nxt = bus.START ? S_ARM : S_WAIT;
      S_WAIT:    nxt = bus.START ? S_SELECT : S_WAIT;
      S_SELECT:  nxt = any_left ? S_INIT : S_DONE;
      S_INIT:    nxt = S_SHIFT;
      S_SHIFT:   nxt = shift_done ? S_CAPT : S_SHIFT;
      S_CAPT:    nxt = pat_done ? S_COMPARE : S_SHIFT;
      S_COMPARE: nxt = S_SELECT;
      S_DONE:    nxt = S_END;
      S_END:     nxt = bus.START ? S_END : S_ARM;
      default:   nxt = S_ARM;
    endcase
  end
  assign bus.INIT = st == S_INIT;
  assign bus.SCAN_EN = st == S_SHIFT;
  assign bus.CAPTURE = st == S_CAPT;
  assign bus.BUSY = st inside {S_SELECT, S_INIT, S_SHIFT, S_CAPT, S_COMPARE, S_DONE};
  assign bus.BIST_END = st == S_END;
  // session bookkeeping: mask latch, CUT routing, per-CUT verdicts and overall GO
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en_q <= '0;
      tested <= '0;
      bus.CUT_SEL <= '0;
      bus.PASS_VEC <= '0;
      bus.GO <= 1'b0;
    end else begin
      if (st == S_WAIT && bus.START) begin
        en_q <= bus.CUT_EN;
        tested <= '0;
        bus.PASS_VEC <= '0;
        bus.GO <= 1'b0;
      end
      if (st == S_SELECT && any_left) begin
        bus.CUT_SEL <= pick;
        tested[pick] <= 1'b1;
      end
      if (st == S_COMPARE)
        bus.PASS_VEC[bus.CUT_SEL] <= bus.MISR_SIG == bus.GOLDEN_SIG[bus.CUT_SEL*SIG_W +: SIG_W];
      if (st == S_DONE) bus.GO <= (|en_q) && ((bus.PASS_VEC & en_q) == en_q);
    end
  end
endmodule

// File: tb/tb_bist_session_scheduler.sv
// tb_bist_session_scheduler: schedule-based reference model with per-cycle compare plus directed scenarios
module tb_bist_session_scheduler;
  localparam int NC = 4, NS = 3, MP = 4, SW = 16;
  typedef struct packed {
    logic init, scan, cap, busy, fin, selv;
    logic [1:0] sel;
    logic [3:0] pv;
    logic go;
  } rec_t;
  logic CLK = 1'b0, RESET = 1'b1;
  bist_if #(.NUM_CUT(NC), .SIG_W(SW)) bus ();
  bist_session_scheduler #(.NUM_CUT(NC), .N_SHIFT(NS), .M_PAT(MP), .SIG_W(SW)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );
  always #5 CLK = ~CLK;
  int pass_cnt = 0, tot_cnt = 0;
  int n_init, n_cap, n_scan, visits, lat;
  logic [3:0] first_pv;
  rec_t q[$];
  rec_t cur = '0;
  int mode = 0;
  bit seen_low = 0;
  logic [3:0] fpv;
  logic fgo;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask
  // expand one session into its cycle-by-cycle expected outputs
  function automatic void build(input logic [3:0] mask, input logic [SW-1:0] misr,
                                input logic [NC*SW-1:0] gold);
    rec_t r;
    logic [3:0] pv = '0;
    q.delete();
    for (int i = 0; i < NC; i++) if (mask[i]) begin
      r = '0; r.busy = 1; r.pv = pv; q.push_back(r);
      r.selv = 1; r.sel = 2'(i); r.init = 1; q.push_back(r);
      r.init = 0;
      for (int p = 0; p < MP; p++) begin
        r.scan = 1;
        for (int s = 0; s < NS; s++) q.push_back(r);
        r.scan = 0; r.cap = 1; q.push_back(r);
        r.cap = 0;
      end
      q.push_back(r);
      pv[i] = gold[i*SW +: SW] == misr;
    end
    r = '0; r.busy = 1; r.pv = pv;
    q.push_back(r);
    q.push_back(r);
    fpv = pv;
    fgo = (mask != 0) && ((pv & mask) == mask);
  endfunction
  // reference model advances on each clock, reset aborts everything
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q.delete(); mode = 0; seen_low = 0; cur = '0;
    end else if (mode == 1) begin
      if (q.size() > 0) cur = q.pop_front();
      else begin
        mode = 2; cur = '0; cur.fin = 1; cur.pv = fpv; cur.go = fgo;
      end
    end else if (mode == 2) begin
      if (!bus.START) begin mode = 0; seen_low = 0; cur.fin = 0; end
    end else begin
      if (seen_low && bus.START) begin
        build(bus.CUT_EN, bus.MISR_SIG, bus.GOLDEN_SIG);
        cur = q.pop_front();
        mode = 1;
      end else if (!bus.START) seen_low = 1;
    end
  end
  // compare DUT to model mid-cycle and gather activity counters
  always @(negedge CLK) begin
    chk("INIT", bus.INIT, cur.init);
    chk("SCAN_EN", bus.SCAN_EN, cur.scan);
    chk("CAPTURE", bus.CAPTURE, cur.cap);
    chk("BUSY", bus.BUSY, cur.busy);
    chk("BIST_END", bus.BIST_END, cur.fin);
    chk("PASS_VEC", bus.PASS_VEC, cur.pv);
    chk("GO", bus.GO, cur.go);
    if (cur.selv) chk("CUT_SEL", bus.CUT_SEL, cur.sel);
    if (bus.INIT) begin n_init++; visits = visits * 4 + int'(bus.CUT_SEL); end
    n_cap += int'(bus.CAPTURE);
    n_scan += int'(bus.SCAN_EN);
  end
  task automatic run_session(input logic [3:0] mask, input logic [3:0] mism, input bit pulse,
                             input bit chg, input int hold);
    logic [SW-1:0] m;
    m = SW'($urandom);
    @(negedge CLK);
    bus.START = 0;
    bus.CUT_EN = mask;
    bus.MISR_SIG = m;
    for (int i = 0; i < NC; i++) bus.GOLDEN_SIG[i*SW +: SW] = mism[i] ? m ^ 16'hA5A5 : m;
    repeat (2) @(negedge CLK);
    n_init = 0; n_cap = 0; n_scan = 0; visits = 0; lat = 0;
    bus.START = 1;
    while (lat < 2000) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) first_pv = bus.PASS_VEC;
      if (bus.BIST_END) break;
      if (pulse) bus.START = $urandom_range(0, 1) == 1;
      if (chg) bus.CUT_EN = 4'($urandom);
    end
    if (!bus.BIST_END) chk("end_timeout", 0, 1);
    bus.START = 1;
    repeat (hold) @(negedge CLK);
    bus.START = 0;
  endtask
  initial begin
    bus.START = 0; bus.CUT_EN = 0; bus.MISR_SIG = 0; bus.GOLDEN_SIG = 0;
    repeat (3) @(negedge CLK);
    chk("reset_outs", {bus.INIT, bus.SCAN_EN, bus.CAPTURE, bus.BUSY, bus.BIST_END,
                       bus.PASS_VEC, bus.GO, bus.CUT_SEL}, 0);
    RESET = 0;
    // all CUTs enabled, all signatures good
    run_session(4'b1111, 4'b0000, 0, 0, 2);
    chk("t1_lat", lat, 79);
    chk("t1_inits", n_init, 4);
    chk("t1_caps", n_cap, 16);
    chk("t1_pv", bus.PASS_VEC, 4'b1111);
    chk("t1_go", bus.GO, 1);
    // sparse mask with CUT3 failing
    run_session(4'b1010, 4'b1000, 0, 0, 2);
    chk("t2_lat", lat, 41);
    chk("t2_visits", visits, 7);
    chk("t2_pv", bus.PASS_VEC, 4'b0010);
    chk("t2_go", bus.GO, 0);
    // empty mask
    run_session(4'b0000, 4'b0000, 0, 0, 2);
    chk("t3_lat", lat, 3);
    chk("t3_inits", n_init, 0);
    chk("t3_scans", n_scan, 0);
    chk("t3_pv", bus.PASS_VEC, 0);
    chk("t3_go", bus.GO, 0);
    // START held high through END must not restart
    run_session(4'b1111, 4'b0000, 0, 0, 20);
    chk("t4_hold_end", bus.BIST_END, 1);
    chk("t4_hold_busy", bus.BUSY, 0);
    run_session(4'b0001, 4'b0000, 0, 0, 2);
    chk("t4_pv_cleared", first_pv, 0);
    chk("t4_pv", bus.PASS_VEC, 4'b0001);
    // reset during CUT2 shifting
    @(negedge CLK);
    bus.CUT_EN = 4'b1111;
    repeat (2) @(negedge CLK);
    bus.START = 1;
    lat = 0;
    while (lat < 500 && !(bus.CUT_SEL == 2 && bus.SCAN_EN)) begin @(negedge CLK); lat++; end
    chk("t5_reached_cut2", bus.CUT_SEL == 2 && bus.SCAN_EN, 1);
    #2 RESET = 1;
    bus.START = 0;
    #1 chk("t5_reset_outs", {bus.INIT, bus.SCAN_EN, bus.CAPTURE, bus.BUSY, bus.BIST_END,
                             bus.PASS_VEC, bus.GO, bus.CUT_SEL}, 0);
    @(negedge CLK);
    RESET = 0;
    run_session(4'b1111, 4'b0000, 0, 0, 2);
    chk("t5_visits", visits, 27);
    // START chatter while busy
    run_session(4'b1111, 4'b0000, 1, 0, 2);
    chk("t6_lat", lat, 79);
    chk("t6_caps", n_cap, 16);
    chk("t6_scans", n_scan, 48);
    // randomized sessions with mid-session mask churn
    for (int k = 0; k < 8; k++)
      run_session(4'($urandom), 4'($urandom), $urandom_range(0, 1) == 1, 1, $urandom_range(1, 4));
    repeat (4) @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
